// File: rtl/add12u_rr_arbiter.sv
// add12u_rr_arbiter: round-robin arbiter that shares one 12-bit unsigned adder
// among NREQ requesters and returns one tagged, registered, back-pressurable
// response per accepted operand pair.
// Build option: define ADD12U_ARB_EXACT_EN to use the exact 13-bit sum instead
// of the approximate add12u_0M4 function.
module add12u_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*12-1:0] req_a,
  input  logic [NREQ*12-1:0] req_b,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [IDW-1:0]     resp_id,
  output logic [12:0]        resp_sum,
  output logic [15:0]        op_count
);

  // Shared adder. Only bit 2 of A feeds the upper add as a carry-in; the low
  // three result bits come straight from the operands.
  function automatic logic [12:0] add_f(input logic [11:0] a, input logic [11:0] b);
`ifdef ADD12U_ARB_EXACT_EN
    return {1'b0, a} + {1'b0, b};
`else
    logic [9:0] hi;
    hi = {1'b0, a[11:3]} + {1'b0, b[11:3]} + {9'b0, a[2]};
    return {hi, b[2], b[1], a[0]};
`endif
  endfunction

  logic [IDW-1:0] ptr_q, ptr_d;
  logic           resp_valid_q, resp_valid_d;
  logic [IDW-1:0] resp_id_q, resp_id_d;
  logic [12:0]    resp_sum_q, resp_sum_d;
  logic [15:0]    op_count_q, op_count_d;

  logic [11:0]    a_arr [NREQ];
  logic [11:0]    b_arr [NREQ];
  logic           found;
  logic [IDW-1:0] grant_idx;
  logic [IDW:0]   cand;
  logic           can_accept;
  logic           xfer;

  assign can_accept = !resp_valid_q || resp_ready;
  assign xfer       = rst_n && found && can_accept;

  // Unpack the flat operand buses and drive the one-hot ready vector.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
      assign a_arr[gi]     = req_a[12*gi +: 12];
      assign b_arr[gi]     = req_b[12*gi +: 12];
      assign req_ready[gi] = xfer && (grant_idx == IDW'(gi));
    end
  endgenerate

  // Search req_valid from ptr upward with wrap; the first set bit wins.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(i);
      if (cand >= (IDW+1)'(NREQ)) begin
        cand = cand - (IDW+1)'(NREQ);
      end
      if (!found && req_valid[cand[IDW-1:0]]) begin
        found     = 1'b1;
        grant_idx = cand[IDW-1:0];
      end
    end
  end

  // Next state: load on transfer (overwriting any result being drained),
  // otherwise clear valid on drain, otherwise hold.
  always_comb begin
    ptr_d        = ptr_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_sum_d   = resp_sum_q;
    op_count_d   = op_count_q;
    if (xfer) begin
      resp_valid_d = 1'b1;
      resp_id_d    = grant_idx;
      resp_sum_d   = add_f(a_arr[grant_idx], b_arr[grant_idx]);
      ptr_d        = (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + IDW'(1);
      if (op_count_q != 16'hFFFF) begin
        op_count_d = op_count_q + 16'd1;
      end
    end else if (resp_valid_q && resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_sum_q   <= '0;
      op_count_q   <= '0;
    end else begin
      ptr_q        <= ptr_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_sum_q   <= resp_sum_d;
      op_count_q   <= op_count_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_sum   = resp_sum_q;
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_add12u_rr_arbiter.sv
// Scoreboard bench for add12u_rr_arbiter: the driver pushes expected
// {id,sum} pairs, a negedge monitor pops them as responses are handshaked.
module tb_add12u_rr_arbiter;

  localparam int NREQ = 4;

`ifdef ADD12U_ARB_EXACT_EN
  localparam logic [12:0] EXP_SINGLE = 13'h0008;
  localparam logic [12:0] EXP_CARRY  = 13'h1000;
  localparam logic [12:0] S0 = 13'h0003;
  localparam logic [12:0] S1 = 13'h0008;
  localparam logic [12:0] S2 = 13'h01FF;
  localparam logic [12:0] S3 = 13'h1000;
`else
  localparam logic [12:0] EXP_SINGLE = 13'h000B;
  localparam logic [12:0] EXP_CARRY  = 13'h1001;
  localparam logic [12:0] S0 = 13'h0003;
  localparam logic [12:0] S1 = 13'h000C;
  localparam logic [12:0] S2 = 13'h01FE;
  localparam logic [12:0] S3 = 13'h1001;
`endif
  localparam logic [12:0] EXP_R0B = 13'h0030;

  logic               clk;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*12-1:0] req_a;
  logic [NREQ*12-1:0] req_b;
  logic               resp_valid;
  logic               resp_ready;
  logic [1:0]         resp_id;
  logic [12:0]        resp_sum;
  logic [15:0]        op_count;

  int checks   = 0;
  int failures = 0;
  logic [14:0] sb_q [$];
  logic [12:0] sat_sum [4];

  add12u_rr_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_sum(resp_sum),
    .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [11:0] a, input logic [11:0] b);
    req_a[12*i +: 12] = a;
    req_b[12*i +: 12] = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a response is consumed on the next rising edge when valid and
  // ready are both seen high here.
  always @(negedge clk) begin
    if (rst_n && resp_valid && resp_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL resp_unexpected: got id=%0d sum=0x%0h expected none", resp_id, resp_sum);
      end else begin
        logic [14:0] e;
        e = sb_q.pop_front();
        if ({resp_id, resp_sum} !== e) begin
          failures++;
          $display("FAIL resp: got id=%0d sum=0x%0h expected id=%0d sum=0x%0h",
                   resp_id, resp_sum, e[14:13], e[12:0]);
        end
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    req_valid  = 4'hF;
    resp_ready = 1'b0;
    req_a      = '0;
    req_b      = '0;
    sat_sum[0] = S0; sat_sum[1] = S1; sat_sum[2] = S2; sat_sum[3] = S3;

    // Reset state, with requests asserted during reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_id", 32'(resp_id), 32'd0);
    chk("rst_resp_sum", 32'(resp_sum), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);

    // Single request from requester 2
    rst_n = 1'b1;
    req_valid = 4'b0100;
    resp_ready = 1'b1;
    set_op(2, 12'h005, 12'h003);
    sb_q.push_back({2'd2, EXP_SINGLE});
    #1;
    chk("single_req_ready", 32'(req_ready), 32'b0100);
    tick();
    req_valid = 4'b0000;
    chk("single_valid", 32'(resp_valid), 32'd1);
    chk("single_id", 32'(resp_id), 32'd2);
    chk("single_sum", 32'(resp_sum), 32'(EXP_SINGLE));
    chk("single_count", 32'(op_count), 32'd1);

    // Carry-out on requester 3 (ptr=3 wins over 0), then requester 0
    req_valid = 4'b1001;
    set_op(3, 12'hFFF, 12'h001);
    set_op(0, 12'h010, 12'h020);
    sb_q.push_back({2'd3, EXP_CARRY});
    sb_q.push_back({2'd0, EXP_R0B});
    tick();
    req_valid = 4'b0001;
    chk("carry_id", 32'(resp_id), 32'd3);
    tick();
    req_valid = 4'b0000;
    chk("after_wrap_id", 32'(resp_id), 32'd0);
    tick();
    chk("carry_drained", 32'(resp_valid), 32'd0);
    chk("carry_count", 32'(op_count), 32'd3);

    // Fairness from reset: 0,1,2,3,0,1
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_op(0, 12'h001, 12'h002);
    set_op(1, 12'h004, 12'h004);
    set_op(2, 12'h100, 12'h0FF);
    set_op(3, 12'h7FF, 12'h801);
    req_valid = 4'hF;
    resp_ready = 1'b1;
    sb_q.push_back({2'd0, S0});
    sb_q.push_back({2'd1, S1});
    sb_q.push_back({2'd2, S2});
    sb_q.push_back({2'd3, S3});
    sb_q.push_back({2'd0, S0});
    sb_q.push_back({2'd1, S1});
    repeat (6) @(posedge clk);
    #1;
    req_valid = 4'b0000;
    tick();
    chk("fair_drained", 32'(resp_valid), 32'd0);
    chk("fair_count", 32'(op_count), 32'd6);

    // Back-pressure: ptr=2, response stalls for 5 cycles
    resp_ready = 1'b0;
    req_valid = 4'hF;
    sb_q.push_back({2'd2, S2});
    #1;
    chk("bp_first_ready", 32'(req_ready), 32'b0100);
    tick();
    chk("bp_loaded", 32'(resp_valid), 32'd1);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_id_stable", 32'(resp_id), 32'd2);
      chk("bp_sum_stable", 32'(resp_sum), 32'(S2));
      chk("bp_valid_held", 32'(resp_valid), 32'd1);
    end
    resp_ready = 1'b1;
    sb_q.push_back({2'd3, S3});
    #1;
    chk("bp_release_ready", 32'(req_ready), 32'b1000);
    tick();
    req_valid = 4'b0000;
    chk("bp_no_bubble_valid", 32'(resp_valid), 32'd1);
    chk("bp_no_bubble_id", 32'(resp_id), 32'd3);
    chk("bp_no_bubble_sum", 32'(resp_sum), 32'(S3));
    tick();
    chk("bp_drained", 32'(resp_valid), 32'd0);

    // Reset mid-operation with a pending response (grant 1 leaves ptr=2)
    resp_ready = 1'b0;
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b0000;
    chk("mid_pending", 32'(resp_valid), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_valid", 32'(resp_valid), 32'd0);
    chk("mid_rst_count", 32'(op_count), 32'd0);
    chk("mid_rst_id", 32'(resp_id), 32'd0);
    req_valid = 4'b1010;
    resp_ready = 1'b1;
    sb_q.push_back({2'd1, S1});
    sb_q.push_back({2'd3, S3});
    #1;
    chk("mid_first_grant", 32'(req_ready), 32'b0010);
    tick();
    req_valid = 4'b1000;
    tick();
    req_valid = 4'b0000;
    tick();
    chk("mid_drained", 32'(resp_valid), 32'd0);

    // Saturation: 65537 transfers, all requesters valid
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 65537; k++) begin
      sb_q.push_back({2'(k % 4), sat_sum[k % 4]});
    end
    req_valid = 4'hF;
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_count_fffe", 32'(op_count), 32'h0000FFFE);
    tick();
    chk("sat_count_ffff", 32'(op_count), 32'h0000FFFF);
    repeat (2) @(posedge clk);
    #1;
    req_valid = 4'b0000;
    chk("sat_count_held", 32'(op_count), 32'h0000FFFF);
    tick();
    chk("sat_drained", 32'(resp_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
